imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the multi-issue decode stage. Takes a bundle of `LANES` instruction words per cycle, decodes each lane's opcode to select the RISC-V immediate format, and sign-extends the result to `XLEN`. Results are registered behind a valid/ready handshake with a one-entry skid buffer, so the block supports full throughput under back-pressure. It sits between the instruction buffer and the rename/dispatch stage, and carries a synchronous flush.

## Interface
- `LANES`, default 2: instructions per bundle.
- `XLEN`, default 32: immediate output width; legal values are 32 or 64.
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `flush` input, 1 bit: synchronous kill of all held bundles.
- `in_valid` input, 1 bit: the input bundle is valid.
- `in_ready` output, 1 bit: the block can accept a bundle this cycle.
- `in_inst` input, `LANES*32` bits: instruction words; lane *k* is `[32k+31:32k]`.
- `in_lane_vld` input, `LANES` bits: per-lane valid within the bundle.
- `out_valid` output, 1 bit: the output bundle is valid.
- `out_ready` input, 1 bit: the consumer accepts the output bundle.
- `out_imm` output, `LANES*XLEN` bits: per-lane immediates.
- `out_type` output, `LANES*3` bits: per-lane format code.
- `out_lane_vld` output, `LANES` bits: the registered copy of `in_lane_vld`.

## Operation
- Format codes: `NONE`=0, `I`=1, `S`=2, `B`=3, `U`=4, `J`=5, `SH`=6.
- Opcode map, taken from `inst[6:0]`:
  - 0110111 (LUI) and 0010111 (AUIPC) decode to `U`.
  - 1101111 decodes to `J`.
  - 1100111, 0000011 and 1110011 decode to `I`.
  - 0100011 decodes to `S`.
  - 1100011 decodes to `B`.
  - 0010011 decodes to `SH` when funct3 is 001 or 101; otherwise it decodes to `I`.
  - Any other opcode decodes to `NONE`.
- Immediate values:
  - `I`, `S`, `B` and `J` are standard RISC-V bit placements, sign-extended from `inst[31]` to `XLEN`.
  - `U` is `{inst[31:12], 12'b0}`, sign-extended to `XLEN`.
  - `SH` is zero-extended: `inst[24:20]` when `XLEN`=32, `inst[25:20]` when `XLEN`=64.
  - `NONE` gives an immediate of 0.
- Lanes with `in_lane_vld`=0 are forced to `out_type`=`NONE` and `out_imm`=0.
- Accept rule: a bundle is accepted when `in_valid && in_ready`.
- Storage: an output register plus one skid register.
  - On accept, the new bundle goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output register drains and the skid register is full, the skid entry moves to the output register.
- `in_ready` is `!skid_full`. It is registered, and it does not depend combinationally on `out_ready`.
- While `out_valid && !out_ready`, `out_imm`, `out_type` and `out_lane_vld` must hold stable.
- `flush`:
  - Clears both entries at the next edge, so `out_valid`=0 in the next cycle.
  - Takes priority over a same-cycle accept and a same-cycle drain; the accepted bundle is discarded.
  - `in_ready` is 1 in the cycle after a flush.
- Reset: `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_type`=0, `out_lane_vld`=0, skid register empty. Asserting reset mid-operation discards all held bundles immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: a bundle accepted at edge *n* has `out_valid`=1 after edge *n*.
- Throughput is one bundle per cycle while `out_ready`=1.
- Under a stall, one extra bundle is absorbed; `in_ready` falls in the cycle after the skid register fills.
- Simultaneous accept and drain with the skid register full: the skid entry moves to the output register and the new bundle enters the skid register; `in_ready` stays 0.
- Order is strictly FIFO; no bundle is dropped except by `flush` or `reset`.

## Structure
- The format codes, opcode constants and the legal `XLEN` values belong in the shared `param.v` header.
- Sub-module `imm_decode_lane` is purely combinational: a 32-bit instruction in, the `XLEN` immediate and 3-bit type out. It is instantiated `LANES` times with a generate loop.
- The top level holds only the handshake, the output register and the skid register.

## Test plan
- `XLEN`=32, lane 0 = 0xFFF00093 (addi x1,x0,-1), `out_ready`=1 → `out_type`=`I`, imm 0xFFFFFFFF, one cycle later.
- Lane 0 = 0x00112623 (sw) → `S`, 0x0000000C. Lane 1 = 0xFFDFF06F (jal) → `J`, 0xFFFFFFFC. Both lanes are checked in the same bundle.
- `XLEN`=64:
  - 0x800002B7 (lui) → `U`, 0xFFFFFFFF80000000.
  - 0x00509093 (slli) → `SH`, 5.
  - 0x02009093 → `SH`, 32.
- Back-pressure: `out_ready`=0 while 3 bundles are offered back-to-back.
  - Bundles 1 and 2 are accepted; `in_ready`=0 from cycle 2.
  - Output holds bundle 1 stable.
  - On release, bundles 1, 2 and 3 emerge in order with no gaps.
- Flush with both entries full and `in_valid`=1 → the next cycle has `out_valid`=0 and `in_ready`=1, and no flushed bundle ever appears.
- Reset asserted asynchronously mid-stall → outputs go to their reset values before the next edge. Lane with `in_lane_vld`=0 and inst 0xFFF00093 → `NONE`, imm 0.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared format codes, opcode constants and the opcode-to-format decode used by the immediate generator.
package imm_gen_pipe_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // Select the immediate format from opcode and, for OP-IMM, funct3 (shifts carry a shamt).
  function automatic imm_fmt_e fmt_of(input logic [INST_W-1:0] inst);
    imm_fmt_e fmt;
    fmt = FMT_NONE;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
      OPC_JAL:                         fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_SYSTEM:  fmt = FMT_I;
      OPC_STORE:                       fmt = FMT_S;
      OPC_BRANCH:                      fmt = FMT_B;
      OPC_OP_IMM: begin
        if ((inst[14:12] == F3_SLLI) || (inst[14:12] == F3_SRXI)) fmt = FMT_SH;
        else                                                      fmt = FMT_I;
      end
      default:                         fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational single-lane immediate decoder: instruction word in, XLEN immediate and format code out.
module imm_decode_lane
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_vld,
  output logic [XLEN-1:0]   o_imm_c,
  output logic [FMT_W-1:0]  o_type_c
);

  imm_fmt_e           w_fmt;
  logic signed [31:0] w_imm32;
  logic [5:0]         w_shamt;

  // Decode format, build the 32-bit signed immediate, then widen (sign for most, zero for shamt).
  always_comb begin
    w_fmt   = FMT_NONE;
    w_imm32 = '0;
    w_shamt = '0;
    if (i_vld) w_fmt = fmt_of(i_inst);
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                          i_inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_inst[31:12], 12'h000};
      FMT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    if (XLEN == XLEN_64) w_shamt = i_inst[25:20];
    else                 w_shamt = {1'b0, i_inst[24:20]};
    o_type_c = w_fmt;
    if (w_fmt == FMT_SH) o_imm_c = XLEN'(w_shamt);
    else                 o_imm_c = XLEN'(w_imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator with a registered output stage and a one-entry skid buffer.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*INST_W-1:0]  in_inst,
  input  logic [LANES-1:0]         in_lane_vld,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*XLEN-1:0]    out_imm,
  output logic [LANES*FMT_W-1:0]   out_type,
  output logic [LANES-1:0]         out_lane_vld
);

  localparam int unsigned IMM_W = LANES * XLEN;
  localparam int unsigned TYP_W = LANES * FMT_W;

  logic [IMM_W-1:0] w_imm;
  logic [TYP_W-1:0] w_type;

  logic             r_out_valid;
  logic [IMM_W-1:0] r_out_imm;
  logic [TYP_W-1:0] r_out_type;
  logic [LANES-1:0] r_out_lvld;
  logic             r_skid_full;
  logic [IMM_W-1:0] r_skid_imm;
  logic [TYP_W-1:0] r_skid_type;
  logic [LANES-1:0] r_skid_lvld;
  logic             r_in_ready;

  logic w_accept;
  logic w_out_free;
  logic w_out_valid_nxt;
  logic w_skid_full_nxt;
  logic w_load_out;
  logic w_out_from_skid;
  logic w_load_skid;

  // One combinational decoder per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .i_inst   (in_inst[k*INST_W +: INST_W]),
      .i_vld    (in_lane_vld[k]),
      .o_imm_c  (w_imm[k*XLEN +: XLEN]),
      .o_type_c (w_type[k*FMT_W +: FMT_W])
    );
  end

  // Occupancy and load-enable decisions; flush overrides any accept or drain.
  always_comb begin
    w_accept        = in_valid & r_in_ready;
    w_out_free      = ~r_out_valid | out_ready;
    w_out_valid_nxt = r_out_valid;
    w_skid_full_nxt = r_skid_full;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_out_valid_nxt = 1'b0;
      w_skid_full_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        w_load_out      = 1'b1;
        w_out_from_skid = 1'b1;
        w_out_valid_nxt = 1'b1;
        w_load_skid     = w_accept;
        w_skid_full_nxt = w_accept;
      end else begin
        w_load_out      = w_accept;
        w_out_valid_nxt = w_accept;
      end
    end else if (w_accept) begin
      w_load_skid     = 1'b1;
      w_skid_full_nxt = 1'b1;
    end
  end

  // Handshake state; in_ready is registered so it never depends on out_ready in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_skid_full <= w_skid_full_nxt;
      r_in_ready  <= ~w_skid_full_nxt;
    end
  end

  // Output payload register; loads either the skid entry or the freshly decoded bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_imm  <= '0;
      r_out_type <= '0;
      r_out_lvld <= '0;
    end else if (w_load_out) begin
      if (w_out_from_skid) begin
        r_out_imm  <= r_skid_imm;
        r_out_type <= r_skid_type;
        r_out_lvld <= r_skid_lvld;
      end else begin
        r_out_imm  <= w_imm;
        r_out_type <= w_type;
        r_out_lvld <= in_lane_vld;
      end
    end
  end

  // Skid payload register; captures a bundle accepted while the output register is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_imm  <= '0;
      r_skid_type <= '0;
      r_skid_lvld <= '0;
    end else if (w_load_skid) begin
      r_skid_imm  <= w_imm;
      r_skid_type <= w_type;
      r_skid_lvld <= in_lane_vld;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_imm      = r_out_imm;
  assign out_type     = r_out_type;
  assign out_lane_vld = r_out_lvld;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are compared to a FIFO-level model.
module tb_imm_gen_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [63:0]  in_inst;
  logic [1:0]   in_lane_vld;

  logic         rdy32, ov32;
  logic [63:0]  imm32;
  logic [5:0]   typ32;
  logic [1:0]   lv32;
  logic         rdy64, ov64;
  logic [127:0] imm64;
  logic [5:0]   typ64;
  logic [1:0]   lv64;

  typedef struct packed {
    logic [63:0] inst;
    logic [1:0]  vld;
  } bundle_t;

  bundle_t q[$];
  bit      last_acc;
  int      n_checks = 0;
  int      n_fail   = 0;

  imm_gen_pipe #(.LANES(2), .XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_lane_vld(in_lane_vld), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_type(typ32), .out_lane_vld(lv32)
  );

  imm_gen_pipe #(.LANES(2), .XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_lane_vld(in_lane_vld), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(typ64), .out_lane_vld(lv64)
  );

  initial forever #5 clk = ~clk;

  // Reference decode from the format table: returns {type, 64-bit immediate} for the given XLEN.
  function automatic logic [66:0] ref_lane(input logic [31:0] inst, input logic vld, input int xlen);
    logic [2:0]  t;
    logic [63:0] v;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] u32;
    t = 3'd0;
    v = 64'd0;
    if (vld) begin
      case (inst[6:0])
        7'h37, 7'h17:        t = 3'd4;
        7'h6F:               t = 3'd5;
        7'h67, 7'h03, 7'h73: t = 3'd1;
        7'h23:               t = 3'd2;
        7'h63:               t = 3'd3;
        7'h13:               t = (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) ? 3'd6 : 3'd1;
        default:             t = 3'd0;
      endcase
    end
    s12 = {inst[31:25], inst[11:7]};
    b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    u32 = {inst[31:12], 12'h000};
    case (t)
      3'd1:    v = 64'($signed(inst[31:20]));
      3'd2:    v = 64'($signed(s12));
      3'd3:    v = 64'($signed(b13));
      3'd4:    v = 64'($signed(u32));
      3'd5:    v = 64'($signed(j21));
      3'd6:    v = (xlen == 64) ? 64'(inst[25:20]) : 64'(inst[24:20]);
      default: v = 64'd0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {t, v};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h73;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h63;
      8, 9: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: the model is a FIFO of depth 2 updated from the inputs seen at the edge.
  task automatic tick();
    bit acc, drn;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (reset || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{inst: in_inst, vld: in_lane_vld});
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b/%b want 0", ov32, ov64);
    end
    n_checks++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b/%b want 1", rdy32, rdy64);
    end
    n_checks++;
    if (imm32 !== '0 || imm64 !== '0 || typ32 !== '0 || typ64 !== '0 || lv32 !== '0 || lv64 !== '0) begin
      n_fail++; $display("FAIL reset_payload got imm32=%h imm64=%h typ=%h/%h lv=%b/%b want 0",
                         imm32, imm64, typ32, typ64, lv32, lv64);
    end
  endtask

  task automatic test_decode_32();
    idle(2);
    in_valid    = 1'b1;
    in_inst     = {32'hFFF00093, 32'hFFF00093};
    in_lane_vld = 2'b01;
    tick();
    n_checks++;
    if (ov32 !== 1'b1 || typ32[2:0] !== 3'd1 || imm32[31:0] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL addi_lane0 got v=%b t=%0d imm=%h want v=1 t=1 imm=ffffffff",
                         ov32, typ32[2:0], imm32[31:0]);
    end
    n_checks++;
    if (typ32[5:3] !== 3'd0 || imm32[63:32] !== 32'h0 || lv32 !== 2'b01) begin
      n_fail++; $display("FAIL invalid_lane1 got t=%0d imm=%h lv=%b want t=0 imm=0 lv=01",
                         typ32[5:3], imm32[63:32], lv32);
    end
    in_inst     = {32'hFFDFF06F, 32'h00112623};
    in_lane_vld = 2'b11;
    tick();
    n_checks++;
    if (ov32 !== 1'b1 || typ32[2:0] !== 3'd2 || imm32[31:0] !== 32'h0000000C) begin
      n_fail++; $display("FAIL sw_lane0 got v=%b t=%0d imm=%h want v=1 t=2 imm=0000000c",
                         ov32, typ32[2:0], imm32[31:0]);
    end
    n_checks++;
    if (typ32[5:3] !== 3'd5 || imm32[63:32] !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL jal_lane1 got t=%0d imm=%h want t=5 imm=fffffffc",
                         typ32[5:3], imm32[63:32]);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (ov32 !== 1'b0) begin
      n_fail++; $display("FAIL decode32_empty got v=%b want 0", ov32);
    end
  endtask

  task automatic test_decode_64();
    idle(2);
    in_valid    = 1'b1;
    in_inst     = {32'h00509093, 32'h800002B7};
    in_lane_vld = 2'b11;
    tick();
    n_checks++;
    if (ov64 !== 1'b1 || typ64[2:0] !== 3'd4 || imm64[63:0] !== 64'hFFFFFFFF80000000) begin
      n_fail++; $display("FAIL lui64 got v=%b t=%0d imm=%h want v=1 t=4 imm=ffffffff80000000",
                         ov64, typ64[2:0], imm64[63:0]);
    end
    n_checks++;
    if (typ64[5:3] !== 3'd6 || imm64[127:64] !== 64'd5) begin
      n_fail++; $display("FAIL slli64 got t=%0d imm=%h want t=6 imm=5", typ64[5:3], imm64[127:64]);
    end
    n_checks++;
    if (imm32[31:0] !== 32'h80000000 || imm32[63:32] !== 32'd5) begin
      n_fail++; $display("FAIL lui_slli32 got %h/%h want 80000000/5", imm32[31:0], imm32[63:32]);
    end
    in_inst = {32'h00000013, 32'h02009093};
    tick();
    n_checks++;
    if (typ64[2:0] !== 3'd6 || imm64[63:0] !== 64'd32) begin
      n_fail++; $display("FAIL shamt32_64 got t=%0d imm=%h want t=6 imm=32", typ64[2:0], imm64[63:0]);
    end
    n_checks++;
    if (typ32[2:0] !== 3'd6 || imm32[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL shamt32_32 got t=%0d imm=%h want t=6 imm=0", typ32[2:0], imm32[31:0]);
    end
    n_checks++;
    if (typ64[5:3] !== 3'd1 || imm64[127:64] !== 64'd0) begin
      n_fail++; $display("FAIL nop64 got t=%0d imm=%h want t=1 imm=0", typ64[5:3], imm64[127:64]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bundle_t     b[3];
    int          idx;
    logic [66:0] r32, r64;
    idle(2);
    for (int i = 0; i < 3; i++) b[i] = '{inst: {rand_inst(), rand_inst()}, vld: 2'b11};
    idx       = 0;
    out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      in_valid = (idx < 3);
      in_inst  = b[idx < 3 ? idx : 2].inst;
      in_lane_vld = 2'b11;
      tick();
      if (last_acc) idx++;
      r32 = ref_lane(b[0].inst[31:0], 1'b1, 32);
      r64 = ref_lane(b[0].inst[31:0], 1'b1, 64);
      n_checks++;
      if (ov32 !== 1'b1 || rdy32 !== (c == 1) || ov64 !== 1'b1 || rdy64 !== (c == 1)) begin
        n_fail++; $display("FAIL stall_hs c=%0d got v=%b%b rdy=%b%b want v=1 rdy=%b",
                           c, ov32, ov64, rdy32, rdy64, c == 1);
      end
      n_checks++;
      if (imm32[31:0] !== r32[31:0] || typ32[2:0] !== r32[66:64] || imm64[63:0] !== r64[63:0]) begin
        n_fail++; $display("FAIL stall_hold c=%0d got %h/%h t=%0d want %h/%h t=%0d",
                           c, imm32[31:0], imm64[63:0], typ32[2:0], r32[31:0], r64[63:0], r32[66:64]);
      end
    end
    out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      in_valid = (idx < 3);
      in_inst  = b[idx < 3 ? idx : 2].inst;
      tick();
      if (last_acc) idx++;
      if (c < 3) begin
        r32 = ref_lane(b[c].inst[63:32], 1'b1, 32);
        r64 = ref_lane(b[c].inst[63:32], 1'b1, 64);
        n_checks++;
        if (ov32 !== 1'b1 || ov64 !== 1'b1 || imm32[63:32] !== r32[31:0] || imm64[127:64] !== r64[63:0]
            || typ64[5:3] !== r64[66:64]) begin
          n_fail++; $display("FAIL release_order c=%0d got v=%b%b %h/%h want %h/%h",
                             c, ov32, ov64, imm32[63:32], imm64[127:64], r32[31:0], r64[63:0]);
        end
      end else begin
        n_checks++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1) begin
          n_fail++; $display("FAIL release_end got v=%b%b rdy=%b want v=0 rdy=1", ov32, ov64, rdy32);
        end
      end
    end
  endtask

  task automatic test_flush();
    idle(2);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_lane_vld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      in_inst = {rand_inst(), rand_inst()};
      tick();
    end
    in_inst = {rand_inst(), rand_inst()};
    flush   = 1'b1;
    tick();
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL flush_full got v=%b%b rdy=%b%b want v=0 rdy=1", ov32, ov64, rdy32, rdy64);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost i=%0d got v=%b%b want 0", i, ov32, ov64);
      end
    end
    // One entry held, accept in the flush cycle must be discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = {rand_inst(), rand_inst()};
    tick();
    flush   = 1'b1;
    in_inst = {rand_inst(), rand_inst()};
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || ov64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_accept got v=%b%b rdy=%b want v=0 rdy=1", ov32, ov64, rdy32);
    end
    tick();
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_accept_ghost got v=%b%b want 0", ov32, ov64);
    end
  endtask

  task automatic test_async_reset();
    idle(2);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_lane_vld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      in_inst = {rand_inst() | 32'h8000_0000, 32'hFFF00093};
      tick();
    end
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_hs got v=%b%b rdy=%b%b want v=0 rdy=1", ov32, ov64, rdy32, rdy64);
    end
    n_checks++;
    if (imm32 !== '0 || imm64 !== '0 || typ32 !== '0 || typ64 !== '0 || lv32 !== '0 || lv64 !== '0) begin
      n_fail++; $display("FAIL async_reset_payload got imm=%h/%h typ=%h/%h lv=%b/%b want 0",
                         imm32, imm64, typ32, typ64, lv32, lv64);
    end
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_ghost got v=%b%b want 0", ov32, ov64);
    end
  endtask

  task automatic test_random();
    logic [66:0] r32, r64;
    bit          exp_v, exp_r;
    idle(2);
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_inst     = {rand_inst(), rand_inst()};
      in_lane_vld = 2'($urandom_range(0, 3));
      tick();
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      n_checks++;
      if (ov32 !== exp_v || ov64 !== exp_v || rdy32 !== exp_r || rdy64 !== exp_r) begin
        n_fail++; $display("FAIL rand_hs c=%0d got v=%b%b rdy=%b%b want v=%b rdy=%b",
                           c, ov32, ov64, rdy32, rdy64, exp_v, exp_r);
      end
      if (exp_v) begin
        for (int k = 0; k < 2; k++) begin
          r32 = ref_lane(q[0].inst[k*32 +: 32], q[0].vld[k], 32);
          r64 = ref_lane(q[0].inst[k*32 +: 32], q[0].vld[k], 64);
          n_checks++;
          if ({typ32[k*3 +: 3], imm32[k*32 +: 32], lv32[k]} !== {r32[66:64], r32[31:0], q[0].vld[k]}) begin
            n_fail++; $display("FAIL rand_lane32 c=%0d k=%0d got t=%0d imm=%h lv=%b want t=%0d imm=%h lv=%b",
                               c, k, typ32[k*3 +: 3], imm32[k*32 +: 32], lv32[k],
                               r32[66:64], r32[31:0], q[0].vld[k]);
          end
          n_checks++;
          if ({typ64[k*3 +: 3], imm64[k*64 +: 64], lv64[k]} !== {r64[66:64], r64[63:0], q[0].vld[k]}) begin
            n_fail++; $display("FAIL rand_lane64 c=%0d k=%0d got t=%0d imm=%h lv=%b want t=%0d imm=%h lv=%b",
                               c, k, typ64[k*3 +: 3], imm64[k*64 +: 64], lv64[k],
                               r64[66:64], r64[63:0], q[0].vld[k]);
          end
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_inst     = '0;
    in_lane_vld = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    test_reset();
    test_decode_32();
    test_decode_64();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
